// File: rtl/usbf_ssram_arb_pkg.sv
// Shared types for the SSRAM arbiter between the IDMA and the Wishbone slave port.
// Arbiter states are one-hot so each state decode is a single flop.
package usbf_ssram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_W_ACC = 3'b010,
    ST_W_ACK = 3'b100
  } arb_state_t;

  // Returns {write_strobe, read_strobe} for a granted access.
  function automatic logic [1:0] sram_strobes(input logic grant, input logic we);
    return {grant & we, grant & ~we};
  endfunction

endpackage

// File: rtl/usbf_ssram_arb.sv
// Arbitrates one single-port SSRAM between the IDMA (priority) and the Wishbone slave,
// with a bounded-wait counter that forces a Wishbone grant after MAX_WAIT lost cycles.
module usbf_ssram_arb
  import usbf_ssram_arb_pkg::*;
#(
  parameter int SSRAM_HADR = 14,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SSRAM_HADR:0]   madr,
  input  logic [31:0]           mdout,
  output logic [31:0]           mdin,
  input  logic                  mwe,
  input  logic                  mreq,
  output logic                  mack,
  input  logic [SSRAM_HADR:0]   wb_adr,
  input  logic [31:0]           wb_din,
  output logic [31:0]           wb_dout,
  input  logic                  wb_we,
  input  logic                  wb_req,
  output logic                  wb_ack,
  output logic [SSRAM_HADR:0]   sram_adr,
  output logic [31:0]           sram_dout,
  input  logic [31:0]           sram_din,
  output logic                  sram_we,
  output logic                  sram_re
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             wb_ack_q, wb_ack_d;
  logic             wb_forced;
  logic             idma_grant;
  logic             wb_grant;
  logic [1:0]       strobes;

  always_comb begin
    wb_forced  = wb_req && (wait_cnt_q == CNT_W'(MAX_WAIT));
    idma_grant = 1'b0;
    wb_grant   = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wb_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mreq && !wb_forced) begin
          idma_grant = 1'b1;
          if (wb_req && (wait_cnt_q != CNT_W'(MAX_WAIT))) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else if (wb_req) begin
          state_d    = ST_W_ACC;
          wait_cnt_d = '0;
        end
      end
      ST_W_ACC: begin
        wb_grant = 1'b1;
        wb_ack_d = 1'b1;
        state_d  = ST_W_ACK;
      end
      ST_W_ACK: begin
        // The pending WB access was just served, so only the IDMA can be granted here.
        idma_grant = mreq;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!wb_req) begin
      wait_cnt_d = '0;
    end

    // Strobes and grant are combinational, so hold them quiet while reset is asserted.
    if (!rst) begin
      idma_grant = 1'b0;
      wb_grant   = 1'b0;
    end

    strobes = wb_grant ? sram_strobes(1'b1, wb_we) : sram_strobes(idma_grant, mwe);
  end

  assign mack      = idma_grant;
  assign sram_we   = strobes[1];
  assign sram_re   = strobes[0];
  assign sram_adr  = (state_q == ST_W_ACC) ? wb_adr : madr;
  assign sram_dout = (state_q == ST_W_ACC) ? wb_din : mdout;
  assign mdin      = sram_din;
  assign wb_dout   = sram_din;
  assign wb_ack    = wb_ack_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      wb_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wb_ack_q   <= wb_ack_d;
    end
  end

endmodule

// File: tb/tb_usbf_ssram_arb.sv
// Bench for usbf_ssram_arb: directed scenarios plus randomized traffic checked against a
// transaction-level arbitration model and a reference memory.
module tb_usbf_ssram_arb;

  localparam int HADR = 14;
  localparam int MAXW = 4;
  localparam int CW   = 3;
  localparam int AW   = HADR + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] madr = '0, wb_adr = '0, sram_adr;
  logic [31:0]   mdout = '0, wb_din = '0, mdin, wb_dout, sram_dout, sram_din;
  logic          mwe = 1'b0, mreq = 1'b0, mack;
  logic          wb_we = 1'b0, wb_req = 1'b0, wb_ack;
  logic          sram_we, sram_re;

  always #5 clk = ~clk;

  usbf_ssram_arb #(.SSRAM_HADR(HADR), .MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .madr(madr), .mdout(mdout), .mdin(mdin), .mwe(mwe), .mreq(mreq), .mack(mack),
    .wb_adr(wb_adr), .wb_din(wb_din), .wb_dout(wb_dout), .wb_we(wb_we),
    .wb_req(wb_req), .wb_ack(wb_ack),
    .sram_adr(sram_adr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_we(sram_we), .sram_re(sram_re)
  );

  // SSRAM environment: 1-cycle read latency, read data holds until the next read.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_adr = '0;
  logic [31:0]   poke_dat = '0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_adr] <= poke_dat;
    else if (sram_we) mem[sram_adr] <= sram_dout;
    if (sram_re) sram_din <= mem[sram_adr];
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: who owns the memory each cycle, derived from the arbitration rules.
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          wb_phase = 0;   // 0: no WB access in flight, 1: WB uses the SSRAM, 2: WB is acknowledged
  int          wb_losses = 0;  // consecutive cycles a pending WB request lost to the IDMA
  logic        rd_pend = 1'b0;
  logic [31:0] rd_dat = '0;
  logic        wb_was_read = 1'b0;

  logic [3:0]  exp_vec, obs_vec;   // {mack, wb_ack, sram_we, sram_re}
  logic        exp_rd_valid, exp_wb_rd;
  logic [31:0] exp_rd, obs_mdin, obs_wb_dout;

  task automatic cycle();
    logic          acc, acc_we, idma_ok, wb_turn;
    logic [AW-1:0] a;
    logic [31:0]   d;
    @(negedge clk);
    acc = 1'b0; acc_we = 1'b0; a = '0; d = '0;
    idma_ok = 1'b0;
    exp_rd_valid = rd_pend;
    exp_rd = rd_dat;
    exp_wb_rd = 1'b0;
    exp_vec = 4'b0000;
    if (!rst) begin
      wb_phase = 0;
      wb_losses = 0;
      rd_pend = 1'b0;
    end else begin
      wb_turn = (wb_phase == 0) && wb_req && (wb_losses >= MAXW);
      if (wb_phase == 1) begin
        acc = 1'b1; acc_we = wb_we; a = wb_adr; d = wb_din;
        wb_was_read = !wb_we;
      end else begin
        idma_ok = mreq && !wb_turn;
        if (idma_ok) begin
          acc = 1'b1; acc_we = mwe; a = madr; d = mdout;
        end
      end
      exp_wb_rd = (wb_phase == 2) && wb_was_read;
      exp_vec = {idma_ok, wb_phase == 2, acc && acc_we, acc && !acc_we};
      if (wb_phase == 0) begin
        if (wb_req && !idma_ok) begin
          wb_phase = 1;
          wb_losses = 0;
        end else if (wb_req && idma_ok) begin
          wb_losses = (wb_losses + 1 > MAXW) ? MAXW : wb_losses + 1;
        end
      end else begin
        wb_phase = (wb_phase == 1) ? 2 : 0;
      end
      if (!wb_req) wb_losses = 0;
      rd_pend = acc && !acc_we;
      if (acc && !acc_we) rd_dat = ref_mem[a];
      if (acc && acc_we) ref_mem[a] = d;
    end
    obs_vec = {mack, wb_ack, sram_we, sram_re};
    obs_mdin = mdin;
    obs_wb_dout = wb_dout;
    @(posedge clk);
    #1;
  endtask

  // Drives one WB access and waits (bounded) for its acknowledge; lat=-1 on timeout.
  task automatic wb_access(input logic we, input logic [AW-1:0] adr, input logic [31:0] din,
                           output int lat, output logic [31:0] rdata, output int bad);
    lat = -1; rdata = '0; bad = 0;
    wb_req = 1'b1; wb_we = we; wb_adr = adr; wb_din = din;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (obs_vec !== exp_vec) bad++;
      if (exp_rd_valid && obs_mdin !== exp_rd) bad++;
      if (obs_vec[2]) begin
        lat = k;
        rdata = obs_wb_dout;
        break;
      end
    end
    wb_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0; mreq = 1'b1; mwe = 1'b0; wb_req = 1'b1; wb_we = 1'b1;
    for (int i = 0; i < 64; i++) begin
      v = (i == 16) ? 32'hDEADBEEF : $urandom;
      poke_en = 1'b1; poke_adr = AW'(i); poke_dat = v;
      ref_mem[i] = v;
      cycle();
      n_chk++;
      if (obs_vec !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=0000", i, obs_vec);
      end
    end
    poke_en = 1'b0; mreq = 1'b0; wb_req = 1'b0;
    rst = 1'b1;
    cycle();
    n_chk++;
    if (obs_vec !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle got=%b want=0000", obs_vec);
    end
  endtask

  task automatic test_idma_read();
    mreq = 1'b1; mwe = 1'b0; madr = AW'('h10);
    cycle();
    n_chk++;
    if (obs_vec !== 4'b1001) begin
      n_fail++;
      $display("FAIL idma_read_grant got=%b want=1001", obs_vec);
    end
    mreq = 1'b0;
    cycle();
    n_chk++;
    if (obs_mdin !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL idma_read_data got=%h want=deadbeef", obs_mdin);
    end
  endtask

  task automatic test_wb_write_read();
    int lat, bad;
    logic [31:0] rd;
    wb_access(1'b1, AW'('h20), 32'h12345678, lat, rd, bad);
    n_chk++;
    if (lat !== 2 || bad !== 0) begin
      n_fail++;
      $display("FAIL wb_write got lat=%0d bad=%0d want lat=2 bad=0", lat, bad);
    end
    wb_access(1'b0, AW'('h20), 32'h0, lat, rd, bad);
    n_chk++;
    if (lat !== 2 || rd !== 32'h12345678 || bad !== 0) begin
      n_fail++;
      $display("FAIL wb_read got lat=%0d data=%h bad=%0d want lat=2 data=12345678", lat, rd, bad);
    end
  endtask

  // Both requesters rise together with mreq held; returns per-cycle mack/wb_ack patterns.
  task automatic run_contention(output logic [7:0] mk, output logic [7:0] ak, output int bad);
    mk = '0; ak = '0; bad = 0;
    mreq = 1'b1; mwe = 1'b0; madr = AW'('h11);
    wb_req = 1'b1; wb_we = 1'b0; wb_adr = AW'('h12);
    for (int k = 0; k < 8; k++) begin
      cycle();
      mk[k] = obs_vec[3];
      ak[k] = obs_vec[2];
      if (obs_vec !== exp_vec) bad++;
      if (exp_rd_valid && obs_mdin !== exp_rd) bad++;
      if (exp_wb_rd && obs_wb_dout !== exp_rd) bad++;
      if (obs_vec[2]) wb_req = 1'b0;
    end
    mreq = 1'b0; wb_req = 1'b0;
    cycle();
  endtask

  task automatic test_contention();
    logic [7:0] mk, ak;
    int bad;
    run_contention(mk, ak, bad);
    n_chk++;
    if (mk !== 8'b1100_1111 || ak !== 8'b0100_0000) begin
      n_fail++;
      $display("FAIL contention_pattern got mack=%b ack=%b want mack=11001111 ack=01000000", mk, ak);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL contention_model got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_idma_write_during_wacc();
    logic [2:0] mk, ak;
    wb_req = 1'b1; wb_we = 1'b1; wb_adr = AW'('h30); wb_din = 32'h0BADF00D;
    for (int k = 0; k < 3; k++) begin
      cycle();
      mk[k] = obs_vec[3];
      ak[k] = obs_vec[2];
      if (k == 0) begin
        mreq = 1'b1; mwe = 1'b1; madr = AW'('h40); mdout = 32'hA5A5A5A5;
      end
      if (obs_vec[3]) mreq = 1'b0;
    end
    wb_req = 1'b0; mreq = 1'b0;
    cycle();
    n_chk++;
    if (mk !== 3'b100 || ak !== 3'b100) begin
      n_fail++;
      $display("FAIL wacc_idma_delay got mack=%b ack=%b want mack=100 ack=100", mk, ak);
    end
    n_chk++;
    if (mem[AW'('h30)] !== 32'h0BADF00D || mem[AW'('h40)] !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL wacc_both_writes got %h/%h want 0badf00d/a5a5a5a5",
               mem[AW'('h30)], mem[AW'('h40)]);
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    logic [7:0] mk, ak;
    int bad;
    wb_req = 1'b1; wb_we = 1'b1; wb_adr = AW'('h31); wb_din = 32'h00000001;
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1; wb_req = 1'b0;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (obs_vec[2]) acks++;
    end
    n_chk++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_ack got %0d acks want 0", acks);
    end
    // Build up wait credit, reset, and confirm the full IDMA priority window returns.
    mreq = 1'b1; mwe = 1'b0; wb_req = 1'b1; wb_we = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1; mreq = 1'b0; wb_req = 1'b0;
    run_contention(mk, ak, bad);
    n_chk++;
    if (mk !== 8'b1100_1111 || ak !== 8'b0100_0000 || bad !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_counter got mack=%b ack=%b bad=%0d want mack=11001111 ack=01000000",
               mk, ak, bad);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    logic [31:0] rd, val;
    logic [AW-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a = AW'($urandom_range(32, 63));
      val = $urandom;
      wb_access(1'b1, a, val, lat, rd, bad);
      n_chk++;
      if (lat !== 2 || bad !== 0) begin
        n_fail++;
        $display("FAIL b2b_write%0d got lat=%0d bad=%0d want lat=2 bad=0", i, lat, bad);
      end
      wb_access(1'b0, a, 32'h0, lat, rd, bad);
      n_chk++;
      if (lat !== 2 || rd !== val || bad !== 0) begin
        n_fail++;
        $display("FAIL b2b_read%0d got lat=%0d data=%h bad=%0d want lat=2 data=%h", i, lat, rd, bad, val);
      end
    end
    cycle();
  endtask

  task automatic test_random();
    int wb_age;
    wb_age = 0;
    mreq = 1'b0; wb_req = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!mreq && $urandom_range(2) == 0) begin
        mreq = 1'b1; mwe = 1'($urandom_range(1));
        madr = AW'($urandom_range(15)); mdout = $urandom;
      end
      cycle();
      n_chk++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rand_ctl cyc=%0d got=%b want=%b", c, obs_vec, exp_vec);
      end
      if (exp_rd_valid) begin
        n_chk++;
        if (obs_mdin !== exp_rd) begin
          n_fail++;
          $display("FAIL rand_mdin cyc=%0d got=%h want=%h", c, obs_mdin, exp_rd);
        end
      end
      if (exp_wb_rd) begin
        n_chk++;
        if (obs_wb_dout !== exp_rd) begin
          n_fail++;
          $display("FAIL rand_wb_dout cyc=%0d got=%h want=%h", c, obs_wb_dout, exp_rd);
        end
      end
      if (obs_vec[3]) mreq = 1'b0;
      if (wb_req) begin
        if (obs_vec[2]) begin
          n_chk++;
          if (wb_age > MAXW + 2) begin
            n_fail++;
            $display("FAIL rand_wb_latency cyc=%0d got=%0d want<=%0d", c, wb_age, MAXW + 2);
          end
          wb_req = 1'b0;
        end else if (wb_age > 12) begin
          n_chk++;
          n_fail++;
          $display("FAIL rand_wb_timeout cyc=%0d got no ack after %0d cycles", c, wb_age);
          wb_req = 1'b0;
        end else begin
          wb_age++;
        end
      end else if ($urandom_range(2) == 0) begin
        wb_req = 1'b1; wb_we = 1'($urandom_range(1));
        wb_adr = AW'($urandom_range(15)); wb_din = $urandom;
        wb_age = 0;
      end
    end
    mreq = 1'b0; wb_req = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    test_reset();
    test_idma_read();
    test_wb_write_read();
    test_contention();
    test_idma_write_during_wacc();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no end of test want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
